// File: rtl/modulo_correccion_if.sv
// modulo_correccion_if
//   Valid/ready stream bundle for modulo_correccion.
//   The upstream side sends the received codeword, and the downstream side takes the corrected codeword.
//   master: drives datos_cod, valid_in and ready_in. It observes ready_out, datos_corr and valid_out (test/upstream side).
//   slave : the corrector's view of the same signals.
interface modulo_correccion_if;
  logic [7:0] datos_cod;
  logic       valid_in;
  logic       ready_out;
  logic [7:0] datos_corr;
  logic       valid_out;
  logic       ready_in;

  modport master (
    output datos_cod, valid_in, ready_in,
    input  ready_out, datos_corr, valid_out
  );

  modport slave (
    input  datos_cod, valid_in, ready_in,
    output ready_out, datos_corr, valid_out
  );
endinterface

// File: rtl/modulo_correccion.sv
// modulo_correccion
//   Registered SECDED checker/corrector for 8-bit Hamming(8,4)+parity codewords.
//   Bit map: [0]=c0 [1]=c1 [2]=i0 [3]=c2 [4]=i1 [5]=i2 [6]=i3 [7]=p0.
//   Ports:
//     clk, rst   : clock; asynchronous active-high reset
//     bus        : stream in (datos_cod/valid_in/ready_out) and out (datos_corr/valid_out/ready_in)
//     clr_cnt    : synchronous clear of both error counters
//     sindrome   : syndrome of the held word (0 = no position flagged)
//     err_simple : held word had a corrected single error
//     err_doble  : held word had an uncorrectable double error
//     cnt_simple : saturating count of accepted single-error words
//     cnt_doble  : saturating count of accepted double-error words
module modulo_correccion #(
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  modulo_correccion_if.slave bus,
  input  logic               clr_cnt,
  output logic [2:0]         sindrome,
  output logic               err_simple,
  output logic               err_doble,
  output logic [CNT_W-1:0]   cnt_simple,
  output logic [CNT_W-1:0]   cnt_doble
);

  typedef enum logic [0:0] {VACIO = 1'b0, LLENO = 1'b1} estado_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_UNO = CNT_W'(1);

  // Hamming syndrome. Code position k sits at bit k-1.
  function automatic logic [2:0] calc_sindrome(input logic [7:0] d);
    logic s0, s1, s2;
    s0 = d[0] ^ d[2] ^ d[4] ^ d[6];
    s1 = d[1] ^ d[2] ^ d[5] ^ d[6];
    s2 = d[3] ^ d[4] ^ d[5] ^ d[6];
    return {s2, s1, s0};
  endfunction

  // Overall parity of the codeword. Even parity is expected.
  function automatic logic paridad(input logic [7:0] d);
    return ^d;
  endfunction

  estado_t          state_q, state_d;
  logic [7:0]       datos_corr_q, datos_corr_d;
  logic [2:0]       sindrome_q, sindrome_d;
  logic             err_simple_q, err_simple_d;
  logic             err_doble_q, err_doble_d;
  logic [CNT_W-1:0] cnt_simple_q, cnt_simple_d;
  logic [CNT_W-1:0] cnt_doble_q, cnt_doble_d;

  logic       ready_out_s;
  logic       accept_s;
  logic [2:0] sind_s;
  logic       par_s;
  logic [7:0] corr_s;
  logic       simple_s;
  logic       doble_s;

  assign ready_out_s    = (state_q == VACIO) || bus.ready_in;
  assign accept_s       = bus.valid_in && ready_out_s;
  assign bus.ready_out  = ready_out_s;
  assign bus.valid_out  = (state_q == LLENO);
  assign bus.datos_corr = datos_corr_q;
  assign sindrome       = sindrome_q;
  assign err_simple     = err_simple_q;
  assign err_doble      = err_doble_q;
  assign cnt_simple     = cnt_simple_q;
  assign cnt_doble      = cnt_doble_q;

  // Classify the incoming word and build its corrected version.
  always_comb begin
    sind_s   = calc_sindrome(bus.datos_cod);
    par_s    = paridad(bus.datos_cod);
    corr_s   = bus.datos_cod;
    simple_s = 1'b0;
    doble_s  = 1'b0;
    if (sind_s != 3'd0) begin
      if (par_s) begin
        corr_s[sind_s - 3'd1] = ~bus.datos_cod[sind_s - 3'd1];
        simple_s = 1'b1;
      end else begin
        // A nonzero syndrome with even parity means two bits flipped. The word passes through unmodified.
        doble_s = 1'b1;
      end
    end else begin
      if (par_s) begin
        // Only the global parity bit itself is wrong.
        corr_s[7] = ~bus.datos_cod[7];
        simple_s  = 1'b1;
      end else begin
        simple_s = 1'b0;
      end
    end
  end

  // Output-stage occupancy FSM and the load enable for the held word.
  always_comb begin
    state_d      = state_q;
    datos_corr_d = datos_corr_q;
    sindrome_d   = sindrome_q;
    err_simple_d = err_simple_q;
    err_doble_d  = err_doble_q;
    case (state_q)
      VACIO: begin
        if (accept_s) begin
          state_d = LLENO;
        end else begin
          state_d = VACIO;
        end
      end
      LLENO: begin
        if (bus.ready_in) begin
          state_d = accept_s ? LLENO : VACIO;
        end else begin
          state_d = LLENO;
        end
      end
      default: state_d = VACIO;
    endcase
    if (accept_s) begin
      datos_corr_d = corr_s;
      sindrome_d   = sind_s;
      err_simple_d = simple_s;
      err_doble_d  = doble_s;
    end else begin
      datos_corr_d = datos_corr_q;
    end
  end

  // Saturating error counters. A clear takes priority over an increment.
  always_comb begin
    cnt_simple_d = cnt_simple_q;
    cnt_doble_d  = cnt_doble_q;
    if (clr_cnt) begin
      cnt_simple_d = '0;
      cnt_doble_d  = '0;
    end else begin
      if (accept_s && simple_s && (cnt_simple_q != CNT_MAX)) begin
        cnt_simple_d = cnt_simple_q + CNT_UNO;
      end else begin
        cnt_simple_d = cnt_simple_q;
      end
      if (accept_s && doble_s && (cnt_doble_q != CNT_MAX)) begin
        cnt_doble_d = cnt_doble_q + CNT_UNO;
      end else begin
        cnt_doble_d = cnt_doble_q;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= VACIO;
      datos_corr_q <= 8'h00;
      sindrome_q   <= 3'd0;
      err_simple_q <= 1'b0;
      err_doble_q  <= 1'b0;
      cnt_simple_q <= '0;
      cnt_doble_q  <= '0;
    end else begin
      state_q      <= state_d;
      datos_corr_q <= datos_corr_d;
      sindrome_q   <= sindrome_d;
      err_simple_q <= err_simple_d;
      err_doble_q  <= err_doble_d;
      cnt_simple_q <= cnt_simple_d;
      cnt_doble_q  <= cnt_doble_d;
    end
  end

endmodule

// File: tb/tb_modulo_correccion.sv
// tb_modulo_correccion
//   Directed bench for modulo_correccion. It uses two instances: CNT_W=8 for the data path and CNT_W=2 for counter saturation.
module tb_modulo_correccion;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  modulo_correccion_if bus8();
  modulo_correccion_if bus2();

  logic       clr8, clr2;
  logic [2:0] sind8, sind2;
  logic       es8, ed8, es2, ed2;
  logic [7:0] cs8, cd8;
  logic [1:0] cs2, cd2;

  modulo_correccion #(.CNT_W(8)) dut8 (
    .clk(clk), .rst(rst), .bus(bus8), .clr_cnt(clr8), .sindrome(sind8),
    .err_simple(es8), .err_doble(ed8), .cnt_simple(cs8), .cnt_doble(cd8)
  );

  modulo_correccion #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2), .clr_cnt(clr2), .sindrome(sind2),
    .err_simple(es2), .err_doble(ed2), .cnt_simple(cs2), .cnt_doble(cd2)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic comprobar(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic ciclo();
    @(posedge clk);
    #1;
  endtask

  // Check the held word of the 8-bit instance against hand-computed values.
  task automatic chk_out8(input string tag, input logic [7:0] d, input logic [2:0] s,
                          input logic es, input logic ed);
    comprobar({tag, ".valid"}, 32'(bus8.valid_out), 32'd1);
    comprobar({tag, ".datos"}, 32'(bus8.datos_corr), 32'(d));
    comprobar({tag, ".sind"},  32'(sind8), 32'(s));
    comprobar({tag, ".es"},    32'(es8), 32'(es));
    comprobar({tag, ".ed"},    32'(ed8), 32'(ed));
  endtask

  // Each row holds: input codeword, expected corrected word, syndrome, single error, double error.
  logic [7:0] v_in  [8] = '{8'h55, 8'h45, 8'hD5, 8'h56, 8'h54, 8'hBF, 8'hFF, 8'h00};
  logic [7:0] v_out [8] = '{8'h55, 8'h55, 8'h55, 8'h56, 8'h55, 8'hFF, 8'hFF, 8'h00};
  logic [2:0] v_sin [8] = '{3'd0,  3'd5,  3'd0,  3'd3,  3'd1,  3'd7,  3'd0,  3'd0};
  logic       v_es  [8] = '{1'b0,  1'b1,  1'b1,  1'b0,  1'b1,  1'b1,  1'b0,  1'b0};
  logic       v_ed  [8] = '{1'b0,  1'b0,  1'b0,  1'b1,  1'b0,  1'b0,  1'b0,  1'b0};

  int exp_cs = 0;
  int exp_cd = 0;

  initial begin
    rst = 1'b1;
    clr8 = 1'b0; clr2 = 1'b0;
    bus8.datos_cod = 8'h55; bus8.valid_in = 1'b1; bus8.ready_in = 1'b1;
    bus2.datos_cod = 8'h00; bus2.valid_in = 1'b0; bus2.ready_in = 1'b1;

    // Reset with valid_in high.
    ciclo(); ciclo();
    comprobar("rst.valid", 32'(bus8.valid_out), 32'd0);
    comprobar("rst.datos", 32'(bus8.datos_corr), 32'd0);
    comprobar("rst.sind",  32'(sind8), 32'd0);
    comprobar("rst.es",    32'(es8), 32'd0);
    comprobar("rst.ed",    32'(ed8), 32'd0);
    comprobar("rst.cs",    32'(cs8), 32'd0);
    comprobar("rst.cd",    32'(cd8), 32'd0);
    comprobar("rst.ready", 32'(bus8.ready_out), 32'd1);

    // The first accept lands one cycle after reset is released.
    rst = 1'b0;
    ciclo();
    chk_out8("first", 8'h55, 3'd0, 1'b0, 1'b0);
    comprobar("first.cs", 32'(cs8), 32'd0);

    // Back-to-back vectors at full throughput.
    for (int i = 0; i < 8; i++) begin
      bus8.datos_cod = v_in[i];
      ciclo();
      if (v_es[i]) exp_cs++;
      if (v_ed[i]) exp_cd++;
      chk_out8($sformatf("vec%0d", i), v_out[i], v_sin[i], v_es[i], v_ed[i]);
      comprobar($sformatf("vec%0d.cs", i), 32'(cs8), 32'(exp_cs));
      comprobar($sformatf("vec%0d.cd", i), 32'(cd8), 32'(exp_cd));
    end

    // Backpressure: the held word (8'h00) must stay stable.
    bus8.ready_in = 1'b0;
    bus8.datos_cod = 8'h45;
    #1;
    comprobar("bp.ready_out", 32'(bus8.ready_out), 32'd0);
    for (int k = 0; k < 5; k++) begin
      ciclo();
      chk_out8($sformatf("hold%0d", k), 8'h00, 3'd0, 1'b0, 1'b0);
      comprobar($sformatf("hold%0d.rdy", k), 32'(bus8.ready_out), 32'd0);
      comprobar($sformatf("hold%0d.cs", k), 32'(cs8), 32'(exp_cs));
    end
    bus8.ready_in = 1'b1;
    ciclo();
    exp_cs++;
    chk_out8("drain0", 8'h55, 3'd5, 1'b1, 1'b0);
    comprobar("drain0.cs", 32'(cs8), 32'(exp_cs));
    bus8.datos_cod = 8'hD5;
    ciclo();
    exp_cs++;
    chk_out8("drain1", 8'h55, 3'd0, 1'b1, 1'b0);
    bus8.datos_cod = 8'h56;
    ciclo();
    exp_cd++;
    chk_out8("drain2", 8'h56, 3'd3, 1'b0, 1'b1);
    comprobar("drain2.cs", 32'(cs8), 32'(exp_cs));
    comprobar("drain2.cd", 32'(cd8), 32'(exp_cd));
    bus8.valid_in = 1'b0;
    ciclo();
    comprobar("empty.valid", 32'(bus8.valid_out), 32'd0);
    comprobar("empty.ready", 32'(bus8.ready_out), 32'd1);

    // Two-bit counters: saturation and clear priority.
    bus2.datos_cod = 8'h45;
    bus2.valid_in = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      ciclo();
      comprobar($sformatf("sat%0d.cs", k), 32'(cs2), (k > 3) ? 32'd3 : 32'(k));
    end
    clr2 = 1'b1;
    ciclo();
    comprobar("clr.cs",    32'(cs2), 32'd0);
    comprobar("clr.datos", 32'(bus2.datos_corr), 32'h55);
    comprobar("clr.es",    32'(es2), 32'd1);
    clr2 = 1'b0;
    bus2.datos_cod = 8'h56;
    ciclo();
    comprobar("post.cs", 32'(cs2), 32'd0);
    comprobar("post.cd", 32'(cd2), 32'd1);
    comprobar("post.ed", 32'(ed2), 32'd1);
    bus2.valid_in = 1'b0;

    // Asynchronous reset in the middle of a held word.
    bus8.valid_in = 1'b1;
    bus8.datos_cod = 8'h45;
    ciclo();
    chk_out8("pre_arst", 8'h55, 3'd5, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    comprobar("arst.valid", 32'(bus8.valid_out), 32'd0);
    comprobar("arst.datos", 32'(bus8.datos_corr), 32'd0);
    comprobar("arst.sind",  32'(sind8), 32'd0);
    comprobar("arst.es",    32'(es8), 32'd0);
    comprobar("arst.cs",    32'(cs8), 32'd0);
    comprobar("arst.cd",    32'(cd8), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
